// File: rtl/bias_relu.sv
`default_nettype none
// ============================================================================
// Module   : bias_relu
// Purpose  : Captures a ROWS x COLS signed result matrix and a per-row bias
//            vector, then produces one activation element per clock:
//            result[r][c] = relu(sat32(matrix[r][c] + bias[r])).
//            The finished matrix is held on `result` with `done` high.
// Ports    : clk       - clock, all state updates on rising edge
//            rst       - synchronous active-high reset
//            enable    - start request, sampled only in IDLE and DONE
//            matrix_in - [ROWS][COLS] x 32-bit signed input matrix
//            bias      - [ROWS] x 32-bit signed bias, one per row
//            result    - [ROWS][COLS] x 32-bit activation matrix
//            busy      - high while elements are being produced
//            done      - high while the finished matrix is presented
// Revision : 1.0 - initial release
// ============================================================================
module bias_relu #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int RELU_EN = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [ROWS-1:0][COLS-1:0][31:0]   matrix_in,
  input  logic [ROWS-1:0][31:0]             bias,
  output logic [ROWS-1:0][COLS-1:0][31:0]   result,
  output logic                              busy,
  output logic                              done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] LAST_R = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_C = CW'(COLS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                        state_q, state_d;
  logic [RW-1:0]                     r_q, r_d;
  logic [CW-1:0]                     c_q, c_d;
  logic [ROWS-1:0][COLS-1:0][31:0]   mat_q;
  logic [ROWS-1:0][31:0]             bias_q;
  logic [ROWS-1:0][COLS-1:0][31:0]   result_q;

  logic        capture;
  logic        last_elem;
  logic [31:0] elem;
  logic [31:0] row_bias;
  logic [32:0] sum;
  logic [31:0] sat;
  logic [31:0] act;

  assign capture   = (state_q == S_IDLE) && enable;
  assign last_elem = (r_q == LAST_R) && (c_q == LAST_C);

  // --------------------------------------------------------------------------
  // Datapath: sign-extend both operands to 33 bits so the carry into bit 32
  // exposes overflow; bits [32:31] disagreeing means the sum left 32-bit range.
  // --------------------------------------------------------------------------
  assign elem     = mat_q[r_q][c_q];
  assign row_bias = bias_q[r_q];
  assign sum      = {elem[31], elem} + {row_bias[31], row_bias};

  always_comb begin
    sat = sum[31:0];
    case (sum[32:31])
      2'b01:   sat = 32'h7FFF_FFFF;  // positive overflow
      2'b10:   sat = 32'h8000_0000;  // negative overflow
      default: sat = sum[31:0];
    endcase
  end

  always_comb begin
    act = sat;
    if ((RELU_EN != 0) && sat[31]) begin
      act = 32'h0;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic (row-major walk over the captured matrix)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_RUN;
          r_d     = '0;
          c_d     = '0;
        end
      end
      S_RUN: begin
        if (last_elem) begin
          state_d = S_DONE;
          r_d     = '0;
          c_d     = '0;
        end else if (c_q == LAST_C) begin
          c_d = '0;
          r_d = r_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      S_DONE: begin
        // Holding enable high keeps the result presented; a restart needs
        // enable to drop for at least one edge first.
        if (!enable) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        r_d     = '0;
        c_d     = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // --------------------------------------------------------------------------
  // Capture and result registers. Elements not yet rewritten in the current
  // run keep whatever the previous run left there.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mat_q    <= '0;
      bias_q   <= '0;
      result_q <= '0;
    end else begin
      if (capture) begin
        mat_q  <= matrix_in;
        bias_q <= bias;
      end
      if (state_q == S_RUN) begin
        result_q[r_q][c_q] <= act;
      end
    end
  end

  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_bias_relu.sv
`default_nettype none
// ============================================================================
// Module   : tb_bias_relu
// Purpose  : Directed self-checking bench for bias_relu. Four instances cover
//            2x2 with ReLU, 3x1 saturation without ReLU, 4x4 (input isolation
//            and mid-run reset) and the degenerate 1x1 case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bias_relu;

  logic clk;
  logic rst;

  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: 2x2, ReLU on ----------------
  logic                    en_a;
  logic [1:0][1:0][31:0]   m_a;
  logic [1:0][31:0]        b_a;
  logic [1:0][1:0][31:0]   res_a;
  logic                    busy_a, done_a;

  bias_relu #(.ROWS(2), .COLS(2), .RELU_EN(1)) u_a (
    .clk(clk), .rst(rst), .enable(en_a), .matrix_in(m_a), .bias(b_a),
    .result(res_a), .busy(busy_a), .done(done_a)
  );

  // ---------------- instance B: 3x1, ReLU off ----------------
  logic                    en_b;
  logic [2:0][0:0][31:0]   m_b;
  logic [2:0][31:0]        b_b;
  logic [2:0][0:0][31:0]   res_b;
  logic                    busy_b, done_b;

  bias_relu #(.ROWS(3), .COLS(1), .RELU_EN(0)) u_b (
    .clk(clk), .rst(rst), .enable(en_b), .matrix_in(m_b), .bias(b_b),
    .result(res_b), .busy(busy_b), .done(done_b)
  );

  // ---------------- instance C: 4x4, ReLU on ----------------
  logic                    en_c;
  logic [3:0][3:0][31:0]   m_c;
  logic [3:0][31:0]        b_c;
  logic [3:0][3:0][31:0]   res_c;
  logic                    busy_c, done_c;

  bias_relu #(.ROWS(4), .COLS(4), .RELU_EN(1)) u_c (
    .clk(clk), .rst(rst), .enable(en_c), .matrix_in(m_c), .bias(b_c),
    .result(res_c), .busy(busy_c), .done(done_c)
  );

  // ---------------- instance D: 1x1, ReLU on ----------------
  logic                    en_d;
  logic [0:0][0:0][31:0]   m_d;
  logic [0:0][31:0]        b_d;
  logic [0:0][0:0][31:0]   res_d;
  logic                    busy_d, done_d;

  bias_relu #(.ROWS(1), .COLS(1), .RELU_EN(1)) u_d (
    .clk(clk), .rst(rst), .enable(en_d), .matrix_in(m_d), .bias(b_d),
    .result(res_d), .busy(busy_d), .done(done_d)
  );

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: saturating add then ReLU, computed in wide integer arithmetic.
  function automatic logic [31:0] ref_relu(input int e, input int b);
    longint s;
    s = longint'(e) + longint'(b);
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    if (s < 0) s = 0;
    return 32'(s);
  endfunction

  int cnt_busy;
  int edges;
  int e_c [4][4];
  int bb_c [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst  = 1'b1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
    m_a = '0; b_a = '0; m_b = '0; b_b = '0;
    m_c = '0; b_c = '0; m_d = '0; b_d = '0;
    tick();
    tick();
    rst = 1'b0;

    // ---------------- reset state ----------------
    check("rst_busy_a", {31'd0, busy_a}, 32'd0);
    check("rst_done_a", {31'd0, done_a}, 32'd0);
    check("rst_res_a00", res_a[0][0], 32'd0);
    check("rst_res_c33", res_c[3][3], 32'd0);

    // ---------------- basic 2x2 run ----------------
    m_a[0][0] = 32'd5;   m_a[0][1] = 32'(-3);
    m_a[1][0] = 32'd10;  m_a[1][1] = 32'(-20);
    b_a[0] = 32'd1;      b_a[1] = 32'd4;
    en_a = 1'b1;
    tick();  // E0
    check("a_busy_after_e0", {31'd0, busy_a}, 32'd1);
    cnt_busy = 0;
    edges    = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy_a) cnt_busy++;
      if (done_a) break;
      tick();
      edges++;
    end
    check("a_done", {31'd0, done_a}, 32'd1);
    check("a_busy_cycles", 32'(cnt_busy), 32'd4);
    check("a_latency", 32'(edges), 32'd4);
    check("a_r00", res_a[0][0], 32'd6);
    check("a_r01", res_a[0][1], 32'd0);
    check("a_r10", res_a[1][0], 32'd14);
    check("a_r11", res_a[1][1], 32'd0);

    // enable held in DONE: no restart
    tick(); tick(); tick();
    check("a_hold_done", {31'd0, done_a}, 32'd1);
    check("a_hold_busy", {31'd0, busy_a}, 32'd0);

    // handshake: drop enable one edge, then restart with new data
    m_a[0][0] = 32'd100; m_a[0][1] = 32'(-50);
    m_a[1][0] = 32'd7;   m_a[1][1] = 32'd8;
    b_a[0] = 32'd0;      b_a[1] = 32'd0;
    en_a = 1'b0;
    tick();
    check("a_done_fell", {31'd0, done_a}, 32'd0);
    check("a_keep_r10", res_a[1][0], 32'd14);
    en_a = 1'b1;
    tick();  // E0
    en_a = 1'b0;
    check("a2_busy", {31'd0, busy_a}, 32'd1);
    tick();  // E1 writes (0,0)
    check("a2_r00_new", res_a[0][0], 32'd100);
    check("a2_r10_old", res_a[1][0], 32'd14);
    for (int k = 0; k < 20 && !done_a; k++) tick();
    check("a2_done", {31'd0, done_a}, 32'd1);
    check("a2_r01", res_a[0][1], 32'd0);
    check("a2_r10", res_a[1][0], 32'd7);
    check("a2_r11", res_a[1][1], 32'd8);

    // ---------------- saturation, ReLU off ----------------
    m_b[0][0] = 32'h7FFF_FFF0; b_b[0] = 32'h0000_0100;
    m_b[1][0] = 32'h8000_0010; b_b[1] = 32'hFFFF_FF00;
    m_b[2][0] = 32'(-7);       b_b[2] = 32'd2;
    en_b = 1'b1;
    tick();
    en_b = 1'b0;
    for (int k = 0; k < 20 && !done_b; k++) tick();
    check("b_done", {31'd0, done_b}, 32'd1);
    check("b_sat_pos", res_b[0][0], 32'h7FFF_FFFF);
    check("b_sat_neg", res_b[1][0], 32'h8000_0000);
    check("b_neg_pass", res_b[2][0], 32'hFFFF_FFFB);

    // ---------------- 4x4 input isolation ----------------
    bb_c = '{-3, 1, -10, 2};
    for (int r = 0; r < 4; r++) begin
      b_c[r] = 32'(bb_c[r]);
      for (int c = 0; c < 4; c++) begin
        e_c[r][c] = r * 4 + c - 5;
        m_c[r][c] = 32'(e_c[r][c]);
      end
    end
    en_c = 1'b1;
    tick();  // E0
    en_c = 1'b0;
    for (int k = 0; k < 40 && !done_c; k++) begin
      for (int r = 0; r < 4; r++) begin
        b_c[r] = $urandom;
        for (int c = 0; c < 4; c++) m_c[r][c] = $urandom;
      end
      tick();
    end
    check("c_done", {31'd0, done_c}, 32'd1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        check($sformatf("c_iso_r%0dc%0d", r, c), res_c[r][c], ref_relu(e_c[r][c], bb_c[r]));
    tick();  // DONE -> IDLE

    // ---------------- 4x4 reset mid-run ----------------
    en_c = 1'b1;
    tick();  // E0
    en_c = 1'b0;
    tick();  // E1
    rst = 1'b1;
    tick();  // E2 with reset
    rst = 1'b0;
    check("c_rst_busy", {31'd0, busy_c}, 32'd0);
    check("c_rst_done", {31'd0, done_c}, 32'd0);
    check("c_rst_r00", res_c[0][0], 32'd0);
    check("c_rst_r12", res_c[1][2], 32'd0);
    check("c_rst_r33", res_c[3][3], 32'd0);
    tick();
    check("c_rst_idle", {31'd0, busy_c}, 32'd0);

    for (int r = 0; r < 4; r++) begin
      bb_c[r] = -2000;
      b_c[r]  = 32'(bb_c[r]);
      for (int c = 0; c < 4; c++) begin
        e_c[r][c] = 1000 * (r + 1) - 300 * c;
        m_c[r][c] = 32'(e_c[r][c]);
      end
    end
    en_c = 1'b1;
    tick();  // E0
    en_c = 1'b0;
    edges = 0;
    for (int k = 0; k < 40 && !done_c; k++) begin
      tick();
      edges++;
    end
    check("c2_done", {31'd0, done_c}, 32'd1);
    check("c2_latency", 32'(edges), 32'd16);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        check($sformatf("c2_r%0dc%0d", r, c), res_c[r][c], ref_relu(e_c[r][c], bb_c[r]));

    // ---------------- 1x1 degenerate ----------------
    m_d[0][0] = 32'd9; b_d[0] = 32'd3;
    en_d = 1'b1;
    tick();  // E0
    en_d = 1'b0;
    check("d_busy", {31'd0, busy_d}, 32'd1);
    tick();  // E1
    check("d_done", {31'd0, done_d}, 32'd1);
    check("d_r", res_d[0][0], 32'd12);
    tick();  // DONE -> IDLE
    m_d[0][0] = 32'hFFFF_FFFF; b_d[0] = 32'd0;
    en_d = 1'b1;
    tick();
    en_d = 1'b0;
    tick();
    check("d2_done", {31'd0, done_d}, 32'd1);
    check("d2_relu", res_d[0][0], 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
